mdu: RTL and testbench

Iterative multiply/divide unit that sits beside the ALU in the execute stage and consumes the same A/B register-file operands. It implements the MIPS HI/LO instructions (mult, multu, div, divu, mthi, mtlo) with a start/busy handshake. HI and LO are held in the unit and read directly by the writeback mux for mfhi and mflo. The controller stalls PC update while `Busy` is high.

---
 rtl/mdu_pkg.sv | 10 +
 rtl/mdu_step.sv | 24 ++
 rtl/mdu.sv | 131 +++++++++++++
 tb/tb_mdu.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared HI/LO operation codes for the execute-stage multiply/divide unit
package mdu_pkg;
  localparam logic [2:0] MD_none  = 3'd0;
  localparam logic [2:0] MD_mult  = 3'd1;
  localparam logic [2:0] MD_multu = 3'd2;
  localparam logic [2:0] MD_div   = 3'd3;
  localparam logic [2:0] MD_divu  = 3'd4;
  localparam logic [2:0] MD_mthi  = 3'd5;
  localparam logic [2:0] MD_mtlo  = 3'd6;
endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration, shift-add multiply or restoring shift-subtract divide
// Ports: i_div selects divide, i_acc is the 64-bit {upper,lower} working register,
// i_op is the multiplicand or divisor magnitude, o_acc is the register after one iteration.
// Multiply: lower half holds the multiplier, consumed LSB first while the sum shifts in from the top.
// Divide: lower half holds the dividend, shifted into the remainder while quotient bits enter at bit 0.
module mdu_step (
  input  logic        i_div,
  input  logic [63:0] i_acc,
  input  logic [31:0] i_op,
  output logic [63:0] o_acc
);
  logic [32:0] w_sum;
  logic [32:0] w_rem;
  logic [31:0] w_diff;
  logic        w_ge;
  always_comb begin
    w_sum  = {1'b0, i_acc[63:32]} + (i_acc[0] ? {1'b0, i_op} : 33'd0);
    w_rem  = {i_acc[63:32], i_acc[31]};
    w_ge   = w_rem >= {1'b0, i_op};
    w_diff = w_rem[31:0] - i_op;
    o_acc  = i_div ? (w_ge ? {w_diff, i_acc[30:0], 1'b1} : {w_rem[31:0], i_acc[30:0], 1'b0})
                   : {w_sum, i_acc[31:1]};
  end
endmodule

// File: rtl/mdu.sv
// mdu: iterative MIPS multiply/divide unit with HI/LO registers and start/busy handshake
// Ports: clk, rst_n (async active-low), A/B operands, MDCtr op code, Start request,
// Busy (operation in flight), Done (pulse when HI/LO take a result), HI, LO.
// Optional macro MDU_FAST_MULT_EN: single-cycle multiply, divide stays iterative.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDCtr,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
  localparam int ITER = 32;
  state_e      r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_op;
  logic        r_div;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_is_mul;
  logic        w_is_div;
  logic        w_sgn;
  logic        w_fast;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_prod;
  logic [63:0] w_step;
  logic [63:0] w_fix;
  always_comb begin
    w_is_mul = MDCtr == MD_mult || MDCtr == MD_multu;
    w_is_div = MDCtr == MD_div || MDCtr == MD_divu;
    w_sgn    = MDCtr == MD_mult || MDCtr == MD_div;
    w_a_mag  = (w_sgn && A[31]) ? -A : A;
    w_b_mag  = (w_sgn && B[31]) ? -B : B;
`ifdef MDU_FAST_MULT_EN
    w_fast   = w_is_mul;
    w_prod   = w_sgn ? {{32{A[31]}}, A} * {{32{B[31]}}, B} : {32'd0, A} * {32'd0, B};
`else
    w_fast   = 1'b0;
    w_prod   = '0;
`endif
    // r_neg_q doubles as the product sign for multiplies
    w_fix    = r_div ? {r_neg_r ? -r_acc[63:32] : r_acc[63:32], r_neg_q ? -r_acc[31:0] : r_acc[31:0]}
                     : (r_neg_q ? -r_acc : r_acc);
  end
  mdu_step u_step (
    .i_div (r_div),
    .i_acc (r_acc),
    .i_op  (r_op),
    .o_acc (w_step)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_op    <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (Start) begin
          if (w_is_div && B == '0) begin
            // preload the fixed divide-by-zero result and let FIX write it unsigned
            r_acc   <= {A, 32'hFFFF_FFFF};
            r_div   <= 1'b1;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_FIX;
          end else if (w_fast) begin
            r_acc   <= w_prod;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_FIX;
          end else if (w_is_mul || w_is_div) begin
            r_acc   <= {32'd0, w_is_div ? w_a_mag : w_b_mag};
            r_op    <= w_is_div ? w_b_mag : w_a_mag;
            r_div   <= w_is_div;
            r_neg_q <= w_sgn & (A[31] ^ B[31]);
            r_neg_r <= w_sgn & A[31];
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end else if (MDCtr == MD_mthi) begin
            r_hi   <= A;
            r_done <= 1'b1;
          end else if (MDCtr == MD_mtlo) begin
            r_lo   <= A;
            r_done <= 1'b1;
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(ITER - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          {r_hi, r_lo} <= w_fix;
          r_done       <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign Busy = r_busy;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu with an arithmetic reference model
module tb_mdu;
  import mdu_pkg::*;
`ifdef MDU_FAST_MULT_EN
  localparam int MULT_LAT = 1;
`else
  localparam int MULT_LAT = 33;
`endif
  logic        clk = 0;
  logic        rst_n = 1;
  logic [31:0] A = 0;
  logic [31:0] B = 0;
  logic [2:0]  MDCtr = 0;
  logic        Start = 0;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  mdu dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDCtr(MDCtr), .Start(Start),
           .Busy(Busy), .Done(Done), .HI(HI), .LO(LO));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void model_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] hi, output logic [31:0] lo);
    int sa, sb;
    longint p;
    sa = a;
    sb = b;
    hi = 0;
    lo = 0;
    if (op == MD_mult) begin
      p = longint'(sa) * longint'(sb);
      {hi, lo} = p;
    end else if (op == MD_multu) begin
      {hi, lo} = {32'd0, a} * {32'd0, b};
    end else if (b == 0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else if (op == MD_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      hi = 0;
      lo = 32'h8000_0000;
    end else if (op == MD_div) begin
      lo = sa / sb;
      hi = sa % sb;
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endfunction
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  logic        m_busy = 0, m_done = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1; m_busy = 0;
        end
      end else if (Start) begin
        if (MDCtr == MD_mthi) begin
          m_hi = A; m_done = 1;
        end else if (MDCtr == MD_mtlo) begin
          m_lo = A; m_done = 1;
        end else if (MDCtr >= MD_mult && MDCtr <= MD_divu) begin
          model_result(MDCtr, A, B, p_hi, p_lo);
          m_left = (MDCtr >= MD_div && B == 0) ? 1 : (MDCtr <= MD_multu ? MULT_LAT : 33);
          m_busy = 1;
        end
      end
    end
  end
  always @(negedge clk) begin
    chk("busy", {31'd0, Busy}, {31'd0, m_busy});
    chk("done", {31'd0, Done}, {31'd0, m_done});
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
  end
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input string nm);
    int n;
    @(negedge clk);
    Start = 1; MDCtr = op; A = a; B = b;
    @(negedge clk);
    Start = 0; MDCtr = MD_none; A = $urandom; B = $urandom;
    n = 0;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, n, lat);
    @(negedge clk);
  endtask
  initial begin
    int n;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst hi", HI, 0);
    chk("rst lo", LO, 0);
    chk("rst busy", {31'd0, Busy}, 0);
    chk("rst done", {31'd0, Done}, 0);
    #2 rst_n = 1;
    do_op(MD_mult, 32'hFFFF_FFFE, 32'd3, MULT_LAT, "mult");
    chk("mult hi", HI, 32'hFFFF_FFFF);
    chk("mult lo", LO, 32'hFFFF_FFFA);
    do_op(MD_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, "multu");
    chk("multu hi", HI, 32'hFFFF_FFFE);
    chk("multu lo", LO, 32'h0000_0001);
    do_op(MD_mult, 32'h7FFF_FFFF, 32'h8000_0000, MULT_LAT, "mult big");
    chk("mult big hi", HI, 32'hC000_0000);
    chk("mult big lo", LO, 32'h8000_0000);
    do_op(MD_div, 32'hFFFF_FFF9, 32'd2, 33, "div");
    chk("div lo", LO, 32'hFFFF_FFFD);
    chk("div hi", HI, 32'hFFFF_FFFF);
    do_op(MD_divu, 32'd7, 32'd2, 33, "divu");
    chk("divu lo", LO, 32'd3);
    chk("divu hi", HI, 32'd1);
    do_op(MD_divu, 32'h1234_5678, 32'd0, 1, "divu0");
    chk("divu0 lo", LO, 32'hFFFF_FFFF);
    chk("divu0 hi", HI, 32'h1234_5678);
    do_op(MD_div, 32'hFFFF_FFFB, 32'd0, 1, "div0");
    chk("div0 lo", LO, 32'hFFFF_FFFF);
    chk("div0 hi", HI, 32'hFFFF_FFFB);
    do_op(MD_div, 32'h8000_0000, 32'hFFFF_FFFF, 33, "div ovf");
    chk("div ovf lo", LO, 32'h8000_0000);
    chk("div ovf hi", HI, 32'h0);
    @(negedge clk);
    Start = 1; MDCtr = MD_mthi; A = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("mthi hi", HI, 32'hDEAD_BEEF);
    MDCtr = MD_mtlo; A = 32'd1;
    @(negedge clk);
    Start = 0; MDCtr = MD_none;
    chk("mtlo lo", LO, 32'd1);
    chk("mtlo hi", HI, 32'hDEAD_BEEF);
    @(negedge clk);
    Start = 1; MDCtr = 3'd7; A = 32'h5555_5555; B = 32'd9;
    @(negedge clk);
    Start = 0; MDCtr = MD_none;
    repeat (3) @(negedge clk);
    chk("rsvd hi", HI, 32'hDEAD_BEEF);
    Start = 1; MDCtr = MD_div; A = 32'd100; B = 32'd7;
    @(negedge clk);
    Start = 0; MDCtr = MD_none;
    repeat (5) @(negedge clk);
    Start = 1; MDCtr = MD_mult; A = 32'd3; B = 32'd4;
    @(negedge clk);
    Start = 0; MDCtr = MD_none;
    n = 6;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ignore latency", n, 33);
    chk("ignore lo", LO, 32'd14);
    chk("ignore hi", HI, 32'd2);
    @(negedge clk);
    do_op(MD_mthi, 32'h0000_0055, 32'd0, 0, "preload");
    Start = 1; MDCtr = MD_div; A = 32'd1000; B = 32'd3;
    @(negedge clk);
    Start = 0; MDCtr = MD_none;
    repeat (9) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("abort hi", HI, 0);
    chk("abort lo", LO, 0);
    chk("abort busy", {31'd0, Busy}, 0);
    @(negedge clk);
    #2 rst_n = 1;
    do_op(MD_div, 32'd1000, 32'hFFFF_FFFD, 33, "div after rst");
    chk("div rst lo", LO, 32'hFFFF_FEB3);
    chk("div rst hi", HI, 32'd1);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
